// File: rtl/ser_pkg.sv
// Shared definitions for the serializer-side DRAM port: arbiter state encoding
// and the 8-lane DRAM bus types.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DRAIN = 2'b10
  } arb_state_t;

  typedef logic [7:0][7:0]  dram_lanes_t;
  typedef logic [7:0][63:0] dram_addrs_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_dram_arbiter_if.sv
// Bundle of the master-side request bus and the shared DRAM port seen by the arbiter.
interface ser_dram_arbiter_if
  import ser_pkg::*;
#(
  parameter int NREQ = 2
) ();

  logic        [NREQ-1:0]      req;
  logic        [NREQ-1:0][7:0] m_dram_en;
  logic        [NREQ-1:0]      m_dram_rdwr;
  dram_addrs_t [NREQ-1:0]      m_dram_addr;
  dram_lanes_t [NREQ-1:0]      m_dram_data_out;
  logic        [NREQ-1:0]      gnt;
  logic        [NREQ-1:0][7:0] m_dram_valid;

  logic        [7:0]           dram_en;
  logic                        dram_rdwr;
  dram_addrs_t                 dram_addr;
  dram_lanes_t                 dram_data_out;
  logic        [7:0]           dram_valid;

  modport slave (
    input  req, m_dram_en, m_dram_rdwr, m_dram_addr, m_dram_data_out, dram_valid,
    output gnt, m_dram_valid, dram_en, dram_rdwr, dram_addr, dram_data_out
  );

  modport master (
    output req, m_dram_en, m_dram_rdwr, m_dram_addr, m_dram_data_out, dram_valid,
    input  gnt, m_dram_valid, dram_en, dram_rdwr, dram_addr, dram_data_out
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request bit at or above ptr_i, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   idx_o,
  output logic            found_o
);

  function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] p, int k);
    int s;
    s = int'(p) + k;
    return IW'((s >= NREQ) ? (s - NREQ) : s);
  endfunction

  // Scan from the far end back toward ptr_i so the closest requester wins.
  always_comb begin
    idx_o   = {IW{1'b0}};
    found_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_o   = req_i[wrap_add(ptr_i, k)] ? wrap_add(ptr_i, k) : idx_o;
      found_o = found_o | req_i[wrap_add(ptr_i, k)];
    end
  end

endmodule

// File: rtl/ser_dram_arbiter.sv
// Round-robin owner arbiter for the shared 8-lane DRAM port; the owner keeps the
// port while req is high, then a drain window routes late read returns to it.
module ser_dram_arbiter
  import ser_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int DRAIN_CYCLES = 20
) (
  input  logic              clk,
  input  logic              reset,
  ser_dram_arbiter_if.slave bus
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = idx_width(DRAIN_CYCLES + 1);

  arb_state_t       state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [CW-1:0]    drain_cnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic [7:0]       dram_en_q;
  logic             dram_rdwr_q;
  dram_addrs_t      dram_addr_q;
  dram_lanes_t      dram_data_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [IW-1:0]    owner_inc;
  logic             drain_done;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req_i  (bus.req),
    .ptr_i  (rr_ptr_q),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  assign owner_inc  = (owner_q == IW'(NREQ - 1)) ? {IW{1'b0}} : (owner_q + IW'(1'b1));
  assign drain_done = (int'(drain_cnt_q) == (DRAIN_CYCLES - 1));

  // Ownership FSM; every DRAM-facing output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= {IW{1'b0}};
      rr_ptr_q    <= {IW{1'b0}};
      drain_cnt_q <= {CW{1'b0}};
      gnt_q       <= {NREQ{1'b0}};
      dram_en_q   <= 8'h00;
      dram_rdwr_q <= 1'b0;
      dram_addr_q <= {8{64'h0}};
      dram_data_q <= {8{8'h00}};
    end else begin
      case (state_q)
        IDLE: begin
          dram_en_q <= 8'h00;
          if (pick_found) begin
            owner_q <= pick_idx;
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (bus.req[owner_q]) begin
            dram_en_q   <= bus.m_dram_en[owner_q];
            dram_rdwr_q <= bus.m_dram_rdwr[owner_q];
            dram_addr_q <= bus.m_dram_addr[owner_q];
            dram_data_q <= bus.m_dram_data_out[owner_q];
          end else begin
            gnt_q       <= {NREQ{1'b0}};
            dram_en_q   <= 8'h00;
            drain_cnt_q <= {CW{1'b0}};
            rr_ptr_q    <= owner_inc;
            state_q     <= (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          dram_en_q <= 8'h00;
          gnt_q     <= {NREQ{1'b0}};
          if (drain_done) begin
            state_q <= IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1'b1);
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_q     <= {NREQ{1'b0}};
          dram_en_q <= 8'h00;
        end
      endcase
    end
  end

  // Read returns go only to the owner; anything arriving while idle is dropped.
  always_comb begin
    bus.m_dram_valid = {NREQ{8'h00}};
    for (int i = 0; i < NREQ; i++) begin
      bus.m_dram_valid[i] = ((state_q != IDLE) && (owner_q == IW'(i))) ? bus.dram_valid : 8'h00;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.dram_en       = dram_en_q;
  assign bus.dram_rdwr     = dram_rdwr_q;
  assign bus.dram_addr     = dram_addr_q;
  assign bus.dram_data_out = dram_data_q;

endmodule

// File: tb/tb_ser_dram_arbiter.sv
// Scoreboard bench for ser_dram_arbiter: the driver queues expected events with
// their cycle numbers, a negedge monitor pops and compares as the DUT produces them.
module tb_ser_dram_arbiter;
  import ser_pkg::*;

  typedef struct {
    int          cyc;
    logic [7:0]  en;
    logic        rdwr;
    dram_addrs_t addr;
    dram_lanes_t data;
  } dram_exp_t;

  logic clk;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  int         gcyc_q[$];
  logic [1:0] gval_q[$];
  int         g3cyc_q[$];
  logic [2:0] g3val_q[$];
  dram_exp_t  dq[$];
  int         vcyc_q[$];
  logic [15:0] vval_q[$];

  ser_dram_arbiter_if #(.NREQ(2)) bus ();
  ser_dram_arbiter_if #(.NREQ(3)) bus3 ();

  ser_dram_arbiter #(.NREQ(2), .DRAIN_CYCLES(20)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  ser_dram_arbiter #(.NREQ(3), .DRAIN_CYCLES(20)) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic dram_addrs_t mk_addr(logic [63:0] base);
    dram_addrs_t a;
    for (int l = 0; l < 8; l++) a[l] = base + 64'(l);
    return a;
  endfunction

  function automatic dram_lanes_t mk_data(logic [7:0] b);
    dram_lanes_t d;
    for (int l = 0; l < 8; l++) d[l] = b + 8'(l);
    return d;
  endfunction

  task automatic chk(string nm, logic [639:0] act, logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none (cycle %0d)", nm, cyc);
  endtask

  task automatic to_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(int m, logic [7:0] en, logic rw, logic [63:0] base, logic [7:0] db);
    bus.m_dram_en[m]       = en;
    bus.m_dram_rdwr[m]     = rw;
    bus.m_dram_addr[m]     = mk_addr(base);
    bus.m_dram_data_out[m] = mk_data(db);
  endtask

  task automatic exp_gnt(int c, logic [1:0] g);
    gcyc_q.push_back(c);
    gval_q.push_back(g);
  endtask

  task automatic exp_g3(int c, logic [2:0] g);
    g3cyc_q.push_back(c);
    g3val_q.push_back(g);
  endtask

  task automatic exp_dram(int c, logic [7:0] en, logic rw, logic [63:0] base, logic [7:0] db, bit zero);
    dram_exp_t e;
    e.cyc  = c;
    e.en   = en;
    e.rdwr = rw;
    e.addr = zero ? {8{64'h0}} : mk_addr(base);
    e.data = zero ? {8{8'h00}} : mk_data(db);
    dq.push_back(e);
  endtask

  task automatic exp_val(int c, logic [15:0] v);
    vcyc_q.push_back(c);
    vval_q.push_back(v);
  endtask

  // Monitor: every output change (or nonzero valid) must match the head of its queue.
  initial begin
    logic [1:0]  gp;
    logic [2:0]  g3p;
    logic [7:0]  ep;
    logic        rp;
    dram_addrs_t ap;
    dram_lanes_t dp;
    dram_exp_t   e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.gnt !== gp) begin
          if (gcyc_q.size() == 0) unexpected("gnt_event");
          else begin
            chk("gnt_cycle", cyc, gcyc_q.pop_front());
            chk("gnt_value", bus.gnt, gval_q.pop_front());
          end
        end
        if (bus3.gnt !== g3p) begin
          if (g3cyc_q.size() == 0) unexpected("gnt3_event");
          else begin
            chk("gnt3_cycle", cyc, g3cyc_q.pop_front());
            chk("gnt3_value", bus3.gnt, g3val_q.pop_front());
          end
        end
        if ({bus.dram_en, bus.dram_rdwr, bus.dram_addr, bus.dram_data_out} !== {ep, rp, ap, dp}) begin
          if (dq.size() == 0) unexpected("dram_event");
          else begin
            e = dq.pop_front();
            chk("dram_cycle", cyc, e.cyc);
            chk("dram_en", bus.dram_en, e.en);
            chk("dram_rdwr", bus.dram_rdwr, e.rdwr);
            chk("dram_addr", bus.dram_addr, e.addr);
            chk("dram_data", bus.dram_data_out, e.data);
          end
        end
        if (bus.m_dram_valid !== 16'h0000) begin
          if (vcyc_q.size() == 0) unexpected("valid_event");
          else begin
            chk("valid_cycle", cyc, vcyc_q.pop_front());
            chk("valid_value", bus.m_dram_valid, vval_q.pop_front());
          end
        end
      end
      gp  = bus.gnt;
      g3p = bus3.gnt;
      ep  = bus.dram_en;
      rp  = bus.dram_rdwr;
      ap  = bus.dram_addr;
      dp  = bus.dram_data_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int g;
    int order[4];
    order = '{0, 1, 2, 0};

    reset = 1'b1;
    bus.req = 2'b00;
    bus.m_dram_en = '0;
    bus.m_dram_rdwr = '0;
    bus.m_dram_addr = '0;
    bus.m_dram_data_out = '0;
    bus.dram_valid = 8'h00;
    bus3.req = 3'b000;
    bus3.m_dram_en = '0;
    bus3.m_dram_rdwr = '0;
    bus3.m_dram_addr = '0;
    bus3.m_dram_data_out = '0;
    bus3.dram_valid = 8'h00;
    to_cyc(3);
    reset = 1'b0;

    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_dram_en", bus.dram_en, 8'h00);
    chk("rst_dram_rdwr", bus.dram_rdwr, 1'b0);
    chk("rst_dram_addr", bus.dram_addr, {8{64'h0}});
    chk("rst_dram_data", bus.dram_data_out, {8{8'h00}});
    chk("rst_gnt3", bus3.gnt, 3'b000);
    mon_en = 1'b1;

    // Single master, then re-raise during drain.
    t = cyc;
    cfg(0, 8'hFF, 1'b1, 64'h1000, 8'hA0);
    bus.req = 2'b01;
    exp_gnt(t + 1, 2'b01);
    exp_dram(t + 2, 8'hFF, 1'b1, 64'h1000, 8'hA0, 1'b0);
    to_cyc(t + 4);
    t = cyc;
    bus.req = 2'b00;
    exp_gnt(t + 1, 2'b00);
    exp_dram(t + 1, 8'h00, 1'b1, 64'h1000, 8'hA0, 1'b0);
    to_cyc(t + 1);
    bus.req = 2'b01;
    exp_gnt(t + 22, 2'b01);
    exp_dram(t + 23, 8'hFF, 1'b1, 64'h1000, 8'hA0, 1'b0);
    to_cyc(t + 25);
    t = cyc;
    bus.req = 2'b00;
    exp_gnt(t + 1, 2'b00);
    exp_dram(t + 1, 8'h00, 1'b1, 64'h1000, 8'hA0, 1'b0);
    to_cyc(t + 22);

    // Reset while idle clears the retained address/data.
    t = cyc;
    reset = 1'b1;
    exp_dram(t + 1, 8'h00, 1'b0, 64'h0, 8'h00, 1'b1);
    to_cyc(t + 1);
    reset = 1'b0;

    // Contention from reset: master 0 first, master 1 after the drain.
    t = cyc;
    cfg(1, 8'h0F, 1'b0, 64'h2000, 8'hB0);
    bus.req = 2'b11;
    exp_gnt(t + 1, 2'b01);
    exp_dram(t + 2, 8'hFF, 1'b1, 64'h1000, 8'hA0, 1'b0);
    to_cyc(t + 3);
    t = cyc;
    bus.req = 2'b10;
    exp_gnt(t + 1, 2'b00);
    exp_dram(t + 1, 8'h00, 1'b1, 64'h1000, 8'hA0, 1'b0);
    exp_gnt(t + 22, 2'b10);
    exp_dram(t + 23, 8'h0F, 1'b0, 64'h2000, 8'hB0, 1'b0);

    // Read return steering in GRANT, in DRAIN, and dropped in IDLE.
    to_cyc(t + 24);
    bus.dram_valid = 8'h3C;
    exp_val(t + 24, 16'h3C00);
    to_cyc(t + 25);
    bus.dram_valid = 8'h00;
    to_cyc(t + 26);
    t = cyc;
    bus.req = 2'b00;
    exp_gnt(t + 1, 2'b00);
    exp_dram(t + 1, 8'h00, 1'b0, 64'h2000, 8'hB0, 1'b0);
    to_cyc(t + 15);
    bus.dram_valid = 8'hFF;
    exp_val(t + 15, 16'hFF00);
    to_cyc(t + 16);
    bus.dram_valid = 8'h00;
    to_cyc(t + 25);
    bus.dram_valid = 8'hFF;
    to_cyc(t + 26);
    bus.dram_valid = 8'h00;

    // Isolation: master 1 toggles req and drives lanes during master 0's grant.
    t = cyc;
    cfg(0, 8'h5A, 1'b1, 64'h3000, 8'hC0);
    bus.req = 2'b01;
    exp_gnt(t + 1, 2'b01);
    exp_dram(t + 2, 8'h5A, 1'b1, 64'h3000, 8'hC0, 1'b0);
    to_cyc(t + 2);
    cfg(1, 8'hFF, 1'b1, 64'hDEAD, 8'hEE);
    bus.req = 2'b11;
    to_cyc(t + 5);
    bus.req = 2'b01;
    to_cyc(t + 7);
    cfg(0, 8'h5A, 1'b1, 64'h3100, 8'hC0);
    exp_dram(t + 8, 8'h5A, 1'b1, 64'h3100, 8'hC0, 1'b0);
    to_cyc(t + 9);
    bus.req = 2'b00;
    exp_gnt(t + 10, 2'b00);
    exp_dram(t + 10, 8'h00, 1'b1, 64'h3100, 8'hC0, 1'b0);

    // Master 0 regranted with the pointer at 1, then reset mid-grant.
    to_cyc(t + 10);
    cfg(0, 8'h1F, 1'b1, 64'h3100, 8'hC0);
    bus.req = 2'b01;
    exp_gnt(t + 31, 2'b01);
    exp_dram(t + 32, 8'h1F, 1'b1, 64'h3100, 8'hC0, 1'b0);
    to_cyc(t + 34);
    reset = 1'b1;
    bus.req = 2'b11;
    exp_gnt(t + 35, 2'b00);
    exp_dram(t + 35, 8'h00, 1'b0, 64'h0, 8'h00, 1'b1);
    to_cyc(t + 35);
    reset = 1'b0;
    exp_gnt(t + 36, 2'b01);
    exp_dram(t + 37, 8'h1F, 1'b1, 64'h3100, 8'hC0, 1'b0);
    to_cyc(t + 38);
    bus.req = 2'b10;
    exp_gnt(t + 39, 2'b00);
    exp_dram(t + 39, 8'h00, 1'b1, 64'h3100, 8'hC0, 1'b0);
    exp_gnt(t + 60, 2'b10);
    exp_dram(t + 61, 8'hFF, 1'b1, 64'hDEAD, 8'hEE, 1'b0);
    to_cyc(t + 63);
    bus.req = 2'b00;
    exp_gnt(t + 64, 2'b00);
    exp_dram(t + 64, 8'h00, 1'b1, 64'hDEAD, 8'hEE, 1'b0);
    to_cyc(t + 86);

    // Three-master rotation: each owner holds four cycles, then re-requests.
    t = cyc;
    bus3.req = 3'b111;
    g = t + 1;
    for (int k = 0; k < 4; k++) begin
      exp_g3(g, 3'b001 << order[k]);
      exp_g3(g + 4, 3'b000);
      to_cyc(g + 3);
      if (k == 3) bus3.req = 3'b000;
      else bus3.req[order[k]] = 1'b0;
      to_cyc(g + 4);
      if (k != 3) bus3.req[order[k]] = 1'b1;
      g = g + 25;
    end
    to_cyc(cyc + 5);

    chk("gnt_queue_left", gcyc_q.size(), 0);
    chk("gnt3_queue_left", g3cyc_q.size(), 0);
    chk("dram_queue_left", dq.size(), 0);
    chk("valid_queue_left", vcyc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
